gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Self-checking sweep stage for the two-input gate lab modules. It sits upstream of the gate under test: it drives every input combination onto the gate and onto its behavioural control model. It also sits downstream of both: it samples their outputs, compares them, and reports pass/fail. It replaces the hand-written `$monitor` benches with a synthesizable, clocked sequencer/checker.

Parameters:
- N_IN, 2, number of gate inputs; vec width; sweep covers 2^N_IN vectors.
- SETTLE, 1, cycles a vector is held before sampling; must be >= 1.
- ERR_W, 4, width of mismatch counter (saturating).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  pulse to begin a sweep; honoured only in IDLE or DONE.
- dut_s  input  1  output of gate under test.
- ref_s  input  1  output of control model.
- vec  output  N_IN  input vector driven to both DUT and control; bit 0 = first gate input.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start or reset.
- pass  output  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  output  ERR_W  mismatches seen; saturates at 2^ERR_W-1.
- first_err_vec  output  N_IN  vec of first mismatch; 0 if none.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, settle counter=0, internal err_seen=0. All outputs are registered.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE with start=1:
  - vec<=0, err_cnt<=0, first_err_vec<=0, err_seen<=0, done<=0, pass<=0, busy<=1.
  - Settle counter loaded with SETTLE-1; next state DRIVE.
- DRIVE: vec held. Counter decrements each cycle. When counter==0, go to SAMPLE. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle): compare dut_s != ref_s.
  - On mismatch: err_cnt increments, saturating (no wrap).
  - On mismatch with err_seen=0: first_err_vec<=vec, err_seen<=1.
  - If vec == all-ones: go to DONE. busy<=0, done<=1, pass<=(err_cnt after this sample == 0).
  - Else: vec<=vec+1, counter reloaded, go to DRIVE.
- Latency: done rises exactly 2^N_IN*(SETTLE+1) cycles after the edge at which busy rises. Defaults give 8 cycles.
- start while busy=1: ignored; no restart, no effect on counters.
- start in DONE: restarts immediately with the same IDLE semantics. done drops on that edge.
- vec wrap: never increments past all-ones; the last vector stays on vec while in DONE.
- Reset mid-sweep: immediate return to reset values. No partial result is retained.
- dut_s/ref_s are only observed in SAMPLE; glitches in DRIVE are don't-care.

Optional Feature:
Macro GATE_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch in SAMPLE forces transition to DONE on that edge (busy=0, done=1, pass=0, err_cnt=1, first_err_vec=failing vec). vec holds the failing vector.
- Undefined: the full sweep always completes, as described above.

Decomposition:
- Shared package gate_sweep_pkg holds:
  - state encoding localparams (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the default N_IN/SETTLE/ERR_W constants.
- One natural sub-module: settle_timer. It is a loadable down-counter with a zero flag, reused by future clocked lab stages.
- The FSM, vec register and error logic stay in the top module.

Test Plan:
- Defaults, DUT = NOR-built AND, ref = `a&b`, start pulse → vec sequence 0,1,2,3, two cycles each; done=1 at cycle 8; pass=1, err_cnt=0, first_err_vec=0.
- DUT tied to 1 → mismatches at vec 0,1,2 → err_cnt=3, first_err_vec=0, pass=0, done at cycle 8.
- DUT matches except inverted at vec=2 → err_cnt=1, first_err_vec=2'b10, pass=0.
- start re-pulsed at cycle 3 of a sweep → ignored; done still at cycle 8; results identical to the first scenario.
- rst_n driven low at cycle 5, between clock edges → all outputs 0 before the next edge. Then release reset and pulse start → a clean full sweep with pass=1.
- N_IN=4, ERR_W=2, DUT always wrong → err_cnt saturates at 3. With GATE_SWEEP_STOP_ON_ERR_EN defined, the same stimulus gives done at cycle 2, err_cnt=1, first_err_vec=0.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared constants and state encoding for the gate sweep checker and its timer.
package gate_sweep_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam int unsigned N_IN_DEF   = 2;
   localparam int unsigned SETTLE_DEF = 1;
   localparam int unsigned ERR_W_DEF  = 4;

   typedef enum logic [1:0] {
      StIdle   = IDLE,
      StDrive  = DRIVE,
      StSample = SAMPLE,
      StDone   = DONE
   } state_e;

   // Counter width able to hold SETTLE-1, never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Sweep bus: stimulus/response toward the gate pair plus the checker's result outputs.
interface gate_sweep_checker_if #(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned ERR_W = 4
) ();

   logic             start;
   logic             dut_s;
   logic             ref_s;
   logic [N_IN-1:0]  vec;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [N_IN-1:0]  first_err_vec;

   modport master (
      output start, dut_s, ref_s,
      input  vec, busy, done, pass, err_cnt, first_err_vec
   );

   modport slave (
      input  start, dut_s, ref_s,
      output vec, busy, done, pass, err_cnt, first_err_vec
   );

endinterface

// File: rtl/gate_sweep_checker_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module gate_sweep_checker_settle_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Clocked sweep sequencer/checker for two-input gate labs.
// Define GATE_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF,
   parameter int unsigned ERR_W  = ERR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gate_sweep_checker_if.slave  bus
);

   localparam int unsigned TW = timer_width(SETTLE);
   localparam logic [TW-1:0] LoadVal = TW'(SETTLE - 1);

   state_e           state_q;
   logic [N_IN-1:0]  vec_q;
   logic [N_IN-1:0]  first_err_vec_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic [ERR_W-1:0] err_cnt_nxt;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             err_seen_q;

   logic start_ok;
   logic mismatch;
   logic last_vec;
   logic finish;
   logic tmr_load;
   logic tmr_dec;
   logic tmr_zero;

   always_comb begin
      start_ok    = bus.start && ((state_q == StIdle) || (state_q == StDone));
      mismatch    = (bus.dut_s != bus.ref_s);
      last_vec    = &vec_q;
      err_cnt_nxt = err_cnt_q;
      if (mismatch && !(&err_cnt_q)) begin
         err_cnt_nxt = err_cnt_q + ERR_W'(1);
      end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
      finish      = last_vec || mismatch;
`else
      finish      = last_vec;
`endif
      tmr_load    = start_ok || ((state_q == StSample) && !finish);
      tmr_dec     = (state_q == StDrive);
   end

   gate_sweep_checker_settle_timer #(
      .W (TW)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (LoadVal),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         vec_q           <= '0;
         first_err_vec_q <= '0;
         err_cnt_q       <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_seen_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start_ok) begin
                  vec_q           <= '0;
                  first_err_vec_q <= '0;
                  err_cnt_q       <= '0;
                  err_seen_q      <= 1'b0;
                  busy_q          <= 1'b1;
                  done_q          <= 1'b0;
                  pass_q          <= 1'b0;
                  state_q         <= StDrive;
               end
            end
            StDrive: begin
               if (tmr_zero) begin
                  state_q <= StSample;
               end
            end
            StSample: begin
               err_cnt_q <= err_cnt_nxt;
               if (mismatch && !err_seen_q) begin
                  first_err_vec_q <= vec_q;
                  err_seen_q      <= 1'b1;
               end
               // vec stays on the last (or failing) vector while DONE.
               if (finish) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_cnt_nxt == '0);
                  state_q <= StDone;
               end else begin
                  vec_q   <= vec_q + N_IN'(1);
                  state_q <= StDrive;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.vec           = vec_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_cnt       = err_cnt_q;
   assign bus.first_err_vec = first_err_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: default checker on a 2-input AND lab, plus a 4-input always-wrong gate.
module tb_gate_sweep_checker;

   typedef struct {
      int lat;
      int err;
      int first;
      int pass;
      int vec;
   } exp_t;

   typedef struct {
      int   mode;
      exp_t e;
   } vec_rec_t;

   logic clk;
   logic rst_n;
   logic start_r;
   int   cur;
   int   mode;
   int   n_total;
   int   n_pass;

   exp_t sb[$];

   gate_sweep_checker_if #(.N_IN(2), .ERR_W(4)) bus0 ();
   gate_sweep_checker_if #(.N_IN(4), .ERR_W(2)) bus1 ();

   gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   gate_sweep_checker #(.N_IN(4), .SETTLE(1), .ERR_W(2)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate models: NOR-built AND, a stuck-at-1 gate, and an AND inverted at vec=2.
   logic a, b, nor_and;
   always_comb begin
      a        = bus0.vec[0];
      b        = bus0.vec[1];
      nor_and  = ~(~(a | a) | ~(b | b));
      bus0.ref_s = a & b;
      case (mode)
         1:       bus0.dut_s = 1'b1;
         2:       bus0.dut_s = nor_and ^ (bus0.vec == 2'd2);
         default: bus0.dut_s = nor_and;
      endcase
      bus1.ref_s = &bus1.vec;
      bus1.dut_s = ~(&bus1.vec);
      bus0.start = start_r && (cur == 0);
      bus1.start = start_r && (cur == 1);
   end

   int o_vec, o_busy, o_done, o_pass, o_err, o_first;
   always_comb begin
      if (cur == 1) begin
         o_vec   = int'(bus1.vec);
         o_busy  = int'(bus1.busy);
         o_done  = int'(bus1.done);
         o_pass  = int'(bus1.pass);
         o_err   = int'(bus1.err_cnt);
         o_first = int'(bus1.first_err_vec);
      end else begin
         o_vec   = int'(bus0.vec);
         o_busy  = int'(bus0.busy);
         o_done  = int'(bus0.done);
         o_pass  = int'(bus0.pass);
         o_err   = int'(bus0.err_cnt);
         o_first = int'(bus0.first_err_vec);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"}, o_vec, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_pass"}, o_pass, 0);
      chk({tag, "_err_cnt"}, o_err, 0);
      chk({tag, "_first_err_vec"}, o_first, 0);
   endtask

   // Pulse start, optionally re-pulse while busy, pop the expectation when done rises.
   task automatic run_sweep(input string tag, input int restart_at, input bit chk_vec);
      exp_t e;
      int   lat;
      bit   got;
      @(negedge clk);
      start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      chk({tag, "_busy_rise"}, o_busy, 1);
      chk({tag, "_done_drop"}, o_done, 0);
      if (chk_vec) chk({tag, "_vec0"}, o_vec, 0);
      lat = -1;
      got = 1'b0;
      for (int k = 1; k <= 100 && !got; k++) begin
         @(negedge clk);
         if (k == restart_at) start_r = 1'b1;
         @(posedge clk);
         #1;
         start_r = 1'b0;
         if (o_done == 1) begin
            got = 1'b1;
            lat = k;
         end else if (chk_vec) begin
            chk({tag, "_vec_seq"}, o_vec, k / 2);
         end
      end
      if (sb.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_done_latency"}, lat, e.lat);
         chk({tag, "_err_cnt"}, o_err, e.err);
         chk({tag, "_first_err_vec"}, o_first, e.first);
         chk({tag, "_pass"}, o_pass, e.pass);
         chk({tag, "_busy_end"}, o_busy, 0);
         chk({tag, "_vec_end"}, o_vec, e.vec);
      end
   endtask

   vec_rec_t tbl[3];

   initial begin
      exp_t e;
      n_total = 0;
      n_pass  = 0;
      start_r = 1'b0;
      cur     = 0;
      mode    = 0;

      tbl[0] = '{mode: 0, e: '{lat: 8, err: 0, first: 0, pass: 1, vec: 3}};
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
      tbl[1] = '{mode: 1, e: '{lat: 2, err: 1, first: 0, pass: 0, vec: 0}};
      tbl[2] = '{mode: 2, e: '{lat: 6, err: 1, first: 2, pass: 0, vec: 2}};
`else
      tbl[1] = '{mode: 1, e: '{lat: 8, err: 3, first: 0, pass: 0, vec: 3}};
      tbl[2] = '{mode: 2, e: '{lat: 8, err: 1, first: 2, pass: 0, vec: 3}};
`endif

      rst_n = 1'b0;
      #12;
      cur = 0;
      #1 chk_all_zero("reset0");
      cur = 1;
      #1 chk_all_zero("reset1");
      cur = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Table sweeps; each one after the first also restarts straight from DONE.
      for (int i = 0; i < 3; i++) begin
         mode = tbl[i].mode;
         sb.push_back(tbl[i].e);
         run_sweep($sformatf("tbl%0d", i), 0, (i == 0));
      end

      // Start re-pulsed mid-sweep must be ignored.
      mode = 0;
      sb.push_back(tbl[0].e);
      run_sweep("restart_ignored", 3, 1'b1);

      // Asynchronous reset between edges mid-sweep.
      @(negedge clk);
      start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre_reset_busy", o_busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(tbl[0].e);
      run_sweep("after_reset", 0, 1'b0);

      // Wide gate, narrow counter, always wrong.
      cur = 1;
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
      e = '{lat: 2, err: 1, first: 0, pass: 0, vec: 0};
`else
      e = '{lat: 32, err: 3, first: 0, pass: 0, vec: 15};
`endif
      sb.push_back(e);
      run_sweep("wide_sat", 0, 1'b0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
